// File: rtl/mem_responder.sv
// Word-addressed slow-memory responder: one request at a time, WAIT_CYCLES wait states, then a response.
// Latency accept->resp_valid sampled high is WAIT_CYCLES+2 edges; resp held until resp_ready, req_ready low while busy.
module mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          wait_cnt;
    logic                lat_write;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                in_range;
    logic [IDX_W-1:0]    mem_idx;
    logic [DATA_W-1:0]   rd_word;

    // Contents survive reset; only elaboration zeroes them.
    logic [DATA_W-1:0]   mem [DEPTH] = '{default: '0};

    generate
        if (DEPTH >= (1 << ADDR_W)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            assign in_range = (32'(lat_addr) < 32'(DEPTH));
        end
    endgenerate

    assign mem_idx = lat_addr[IDX_W-1:0];
    assign rd_word = mem[mem_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // <= 1 rather than == 1 so a corrupted count can never wrap and stall.
                if (wait_cnt <= 4'd1) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        busy       = (state_q != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt   <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        wait_cnt  <= WAIT_INIT;
                    end
                end
                ST_WAIT: wait_cnt <= wait_cnt - 4'd1;
                ST_ACCESS: begin
                    if (!in_range) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end else begin
                        resp_rdata <= lat_write ? lat_wdata : rd_word;
                        resp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A reset asserted before the ACCESS edge has already forced IDLE, so the write is dropped.
    always_ff @(posedge clock) begin
        if (state_q == ST_ACCESS && lat_write && in_range) begin
            mem[mem_idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: slow instance (2 wait states, 200 words) and fast instance (0 wait states, full 256 words).
module tb_mem_responder;
    localparam int WA = 2;
    localparam int DA = 200;
    localparam int WB = 0;
    localparam int DB = 256;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    logic        rst_a, req_valid_a, req_ready_a, req_write_a, resp_valid_a, resp_ready_a, resp_err_a, busy_a;
    logic [7:0]  req_addr_a;
    logic [31:0] req_wdata_a, resp_rdata_a;
    logic        rst_b, req_valid_b, req_ready_b, req_write_b, resp_valid_b, resp_ready_b, resp_err_b, busy_b;
    logic [7:0]  req_addr_b;
    logic [31:0] req_wdata_b, resp_rdata_b;

    mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(DA), .WAIT_CYCLES(WA)) dut_a (
        .clock(clock), .reset(rst_a),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
        .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready_a), .resp_rdata(resp_rdata_a),
        .resp_err(resp_err_a), .busy(busy_a)
    );

    mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(DB), .WAIT_CYCLES(WB)) dut_b (
        .clock(clock), .reset(rst_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready_b), .resp_rdata(resp_rdata_b),
        .resp_err(resp_err_b), .busy(busy_b)
    );

    // Reference memories: plain arrays updated per completed store.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    int n_cmp = 0;
    int n_bad = 0;
    int last_acc_b = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready_a), 64'd1);
        check({tag, "_resp_valid"}, 64'(resp_valid_a), 64'd0);
        check({tag, "_rdata"}, 64'(resp_rdata_a), 64'd0);
        check({tag, "_err"}, 64'(resp_err_a), 64'd0);
        check({tag, "_busy"}, 64'(busy_a), 64'd0);
    endtask

    // rst_mode: 0 none, 1 reset during WAIT, 2 reset during RESP.
    task automatic txn_a(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                         input int hold, input int rst_mode);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        exp_err = (int'(addr) >= DA);
        check("a_idle_ready", 64'(req_ready_a), 64'd1);
        req_valid_a = 1'b1; req_write_a = wr; req_addr_a = addr; req_wdata_a = wd; resp_ready_a = 1'b0;
        @(posedge clock); #1;
        req_valid_a = 1'b0;
        req_addr_a  = 8'($urandom);
        req_wdata_a = $urandom;
        req_write_a = 1'($urandom);
        check("a_busy_after_accept", 64'(busy_a), 64'd1);
        if (rst_mode == 1) begin
            rst_a = 1'b0; #1;
            check_reset_a("a_rst_wait");
            @(posedge clock); #1;
            rst_a = 1'b1;
            return;
        end
        if (exp_err) exp_rd = 32'd0;
        else if (wr) begin mem_a[addr] = wd; exp_rd = wd; end
        else exp_rd = mem_a[addr];
        n = 0;
        while (!resp_valid_a && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        // n+1 is the first edge that samples resp_valid high.
        check("a_latency", 64'(n + 1), 64'(WA + 2));
        check("a_rdata", 64'(resp_rdata_a), 64'(exp_rd));
        check("a_err", 64'(resp_err_a), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            req_valid_a = 1'b1;
            req_addr_a  = 8'($urandom);
            @(posedge clock); #1;
            check("a_hold_valid", 64'(resp_valid_a), 64'd1);
            check("a_hold_rdata", 64'(resp_rdata_a), 64'(exp_rd));
            check("a_hold_req_ready", 64'(req_ready_a), 64'd0);
        end
        req_valid_a = 1'b0;
        if (rst_mode == 2) begin
            rst_a = 1'b0; #1;
            check_reset_a("a_rst_resp");
            @(posedge clock); #1;
            rst_a = 1'b1;
            return;
        end
        resp_ready_a = 1'b1;
        @(posedge clock); #1;
        resp_ready_a = 1'b0;
        check("a_post_valid", 64'(resp_valid_a), 64'd0);
        check("a_post_req_ready", 64'(req_ready_a), 64'd1);
        check("a_post_busy", 64'(busy_a), 64'd0);
    endtask

    task automatic txn_b(input logic wr, input logic [7:0] addr, input logic [31:0] wd);
        logic [31:0] exp_rd;
        int          n;
        int          acc;
        check("b_idle_ready", 64'(req_ready_b), 64'd1);
        req_valid_b = 1'b1; req_write_b = wr; req_addr_b = addr; req_wdata_b = wd;
        @(posedge clock); #1;
        acc = cyc;
        req_valid_b = 1'b0;
        req_addr_b  = 8'($urandom);
        req_wdata_b = $urandom;
        if (last_acc_b >= 0) check("b_accept_spacing", 64'(acc - last_acc_b), 64'd3);
        last_acc_b = acc;
        if (wr) begin mem_b[addr] = wd; exp_rd = wd; end
        else exp_rd = mem_b[addr];
        n = 0;
        while (!resp_valid_b && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        check("b_latency", 64'(n + 1), 64'(WB + 2));
        check("b_rdata", 64'(resp_rdata_b), 64'(exp_rd));
        check("b_err", 64'(resp_err_b), 64'd0);
        @(posedge clock); #1;
        check("b_post_valid", 64'(resp_valid_b), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'd0;
            mem_b[i] = 32'd0;
        end
        rst_a = 1'b0; rst_b = 1'b0;
        req_valid_a = 1'b0; req_write_a = 1'b0; req_addr_a = 8'd0; req_wdata_a = 32'd0; resp_ready_a = 1'b0;
        req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = 8'd0; req_wdata_b = 32'd0; resp_ready_b = 1'b1;
        #2;
        check_reset_a("a_reset");
        check("b_reset_req_ready", 64'(req_ready_b), 64'd1);
        check("b_reset_resp_valid", 64'(resp_valid_b), 64'd0);
        check("b_reset_busy", 64'(busy_b), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        rst_a = 1'b1; rst_b = 1'b1;

        txn_a(1'b1, 8'h10, 32'hDEADBEEF, 0, 0);
        txn_a(1'b0, 8'h10, 32'h0, 0, 0);
        txn_a(1'b0, 8'h10, 32'h0, 5, 0);
        txn_a(1'b1, 8'hF0, 32'h12345678, 0, 0);
        txn_a(1'b0, 8'hF0, 32'h0, 0, 0);
        txn_a(1'b1, 8'h20, 32'hAAAA5555, 0, 1);
        txn_a(1'b0, 8'h20, 32'h0, 0, 0);
        txn_a(1'b1, 8'h30, 32'h0BADF00D, 0, 2);
        txn_a(1'b0, 8'h30, 32'h0, 0, 0);
        txn_a(1'b1, 8'hC7, 32'hCAFEF00D, 0, 0);
        txn_a(1'b1, 8'hC8, 32'h55AA55AA, 0, 0);
        for (int k = 0; k < 40; k++) begin
            txn_a(1'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 3)), 0);
        end
        for (int k = 0; k < DA; k++) begin
            txn_a(1'b0, 8'(k), 32'h0, 0, 0);
        end
        txn_a(1'b0, 8'hF0, 32'h0, 0, 0);

        txn_b(1'b1, 8'hFF, 32'h13579BDF);
        txn_b(1'b0, 8'hFF, 32'h0);
        txn_b(1'b0, 8'h00, 32'h0);
        for (int k = 0; k < 30; k++) begin
            txn_b(1'($urandom), 8'($urandom), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's load/store and instruction-fetch requests.
- Accepts one request at a time over a valid/ready handshake and holds a word-addressed storage array.
- Inserts a programmable number of wait states, then returns read data or a write acknowledge over a second valid/ready handshake.
- Sits between the datapath's memory port and on-chip storage, and models slow memory so the control FSM's stall handling can be exercised.

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 8, word-address width.
- DEPTH, 256, number of implemented words; addresses >= DEPTH are out of range.
- WAIT_CYCLES, 2, wait states inserted per access; legal range 0..15.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load/fetch.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  DATA_W  load data; for a store, echoes the stored data.
- resp_err  output  1  address was out of range.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - state IDLE, wait counter 0;
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
- The storage array is not cleared by reset. It is zero-initialised at elaboration only.
- FSM states are IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch req_write, req_addr and req_wdata into internal registers.
  - Then go to WAIT with the counter loaded to WAIT_CYCLES. If WAIT_CYCLES=0, go directly to ACCESS.
- WAIT:
  - req_ready=0.
  - Counter decrements each edge. The edge where the counter equals 1 moves to ACCESS, so exactly WAIT_CYCLES cycles are spent in WAIT.
- ACCESS (one cycle):
  - In-range store: write latched data to mem[addr]; resp_rdata <= wdata; resp_err <= 0.
  - In-range load: resp_rdata <= mem[addr]; resp_err <= 0.
  - Out-of-range address: no write; resp_rdata <= 0; resp_err <= 1.
  - Next state is RESP.
- RESP:
  - resp_valid=1. resp_rdata and resp_err are held stable until the handshake.
  - On an edge with resp_ready=1, go to IDLE; resp_valid falls on that edge.
  - resp_ready=0 holds RESP indefinitely.
- Latency:
  - Request accepted on edge N gives resp_valid high from edge N+WAIT_CYCLES+2.
  - This is 2 edges when WAIT_CYCLES=0.
- Sequencing rules:
  - No request bypass: the earliest next accept is the edge after the response handshake, since req_ready is 1 only in IDLE.
  - Request inputs are ignored outside IDLE. Latched values are used even if req_* inputs change after acceptance.
  - A load to the address of the immediately preceding store returns the new data, because the write completes in ACCESS before a later request can be accepted.
- Reset mid-operation: asynchronous return to IDLE and the pending request is discarded.
  - A store reset before its ACCESS edge must not modify memory.
  - A store whose ACCESS edge completed keeps its write.
- busy=1 in WAIT, ACCESS and RESP.
- Widths: address comparison against DEPTH is unsigned; when DEPTH = 2^ADDR_W, no address is out of range.

Test Plan:
- Store then load, WAIT_CYCLES=2: store addr 0x10 data 0xDEADBEEF, then load 0x10.
  - resp_valid rises 4 edges after each accept.
  - Load returns 0xDEADBEEF with resp_err=0.
- Backpressure: load addr 0x10 with resp_ready held 0 for 5 cycles.
  - resp_valid stays 1 with stable rdata for the 5 cycles.
  - req_ready stays 0 and a second req_valid is not accepted.
  - After resp_ready=1, IDLE is reached and req_ready=1 the next cycle.
- Out of range, DEPTH=200: store addr 0xF0 data 0x12345678.
  - resp_err=1, resp_rdata=0.
  - A subsequent load of 0xF0 also gives resp_err=1, and loads of 0x00..0xC7 are unchanged.
- Zero wait states, WAIT_CYCLES=0: back-to-back loads with resp_ready=1.
  - resp_valid rises 2 edges after each accept.
  - Accepts are spaced exactly 3 cycles.
- Reset mid-WAIT: store addr 0x20 data 0xAAAA5555 (memory previously 0x0), assert reset low during WAIT.
  - All outputs return to reset values immediately, not at the next clock edge.
  - A later load of 0x20 returns 0x00000000.
- Request inputs changing after accept: change req_addr and req_wdata the cycle after acceptance.
  - Response reflects the originally accepted address and data.
